// File: rtl/cpu_pkg.sv
// Shared definitions for the 8080 instruction sequencer: FSM states,
// register codes, write-back source encodings, ALU functions and opcodes.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EX1    = 3'd3,
        ST_EX2    = 3'd4,
        ST_EX3    = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // Instruction class latched in DECODE so the EX states know their role
    typedef enum logic [1:0] {
        CLS_MOV = 2'd0,
        CLS_MVI = 2'd1,
        CLS_ALU = 2'd2
    } insnCls_t;

    localparam logic [2:0] REG_B = 3'd0;
    localparam logic [2:0] REG_C = 3'd1;
    localparam logic [2:0] REG_D = 3'd2;
    localparam logic [2:0] REG_E = 3'd3;
    localparam logic [2:0] REG_H = 3'd4;
    localparam logic [2:0] REG_L = 3'd5;
    localparam logic [2:0] REG_M = 3'd6;
    localparam logic [2:0] REG_A = 3'd7;

    localparam logic [1:0] WB_BUS = 2'b00;
    localparam logic [1:0] WB_REG = 2'b01;
    localparam logic [1:0] WB_ALU = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_ADC = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_SBB = 3'd3;
    localparam logic [2:0] ALU_ANA = 3'd4;
    localparam logic [2:0] ALU_XRA = 3'd5;
    localparam logic [2:0] ALU_ORA = 3'd6;
    localparam logic [2:0] ALU_CMP = 3'd7;

    localparam logic [7:0] OPC_HLT = 8'h76;

endpackage

// File: rtl/cpu_sequencer_reg_onehot_dec.sv
// Register code to one-hot write enable. Code 6 (M, memory) is not a
// register in this datapath, so it never produces an enable.
module reg_onehot_dec
    import cpu_pkg::*;
(
    input  logic       en,
    input  logic [2:0] code,
    output logic [7:0] onehot
);

    // One-hot expansion with M suppressed
    always_comb begin
        onehot = 8'h00;
        if (en && code != REG_M)
            onehot[code] = 1'b1;
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8080 register/ALU
// datapath. Supports MOV r,r / MVI r,imm / ALU r / HLT; anything else is
// flagged illegal and skipped.
// Build option: SINGLE_STEP_EN -- return to IDLE after every completed
// instruction instead of fetching the next one.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int RESET_RUN = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mem_ready,
    input  logic [7:0] rIR_data,
    output logic       fetch_req,
    output logic       rIR_enable,
    output logic [7:0] reg_en,
    output logic [2:0] src_sel,
    output logic [1:0] wb_sel,
    output logic       r1_enable,
    output logic       r2_enable,
    output logic [2:0] alu_op,
    output logic       done,
    output logic       halted,
    output logic       illegal
);

    localparam state_t RST_STATE = (RESET_RUN != 0) ? ST_FETCH : ST_IDLE;
`ifdef SINGLE_STEP_EN
    localparam state_t AFTER_DONE = ST_IDLE;
`else
    localparam state_t AFTER_DONE = ST_FETCH;
`endif

    state_t   state, nextState;
    insnCls_t cls, decCls;
    logic     decValid;
    logic     wrEn;
    logic [2:0] wrCode;

    wire [2:0] irD = rIR_data[5:3];
    wire [2:0] irS = rIR_data[2:0];

    // Classify the opcode currently held in the IR
    always_comb begin
        decValid = 1'b0;
        decCls   = CLS_MOV;
        if (rIR_data[7:6] == 2'b01 && irD != REG_M && irS != REG_M) begin
            decValid = 1'b1;
            decCls   = CLS_MOV;
        end else if (rIR_data[7:6] == 2'b00 && irS == 3'b110 && irD != REG_M) begin
            decValid = 1'b1;
            decCls   = CLS_MVI;
        end else if (rIR_data[7:6] == 2'b10 && irS != REG_M) begin
            decValid = 1'b1;
            decCls   = CLS_ALU;
        end
    end

    // State register and latched instruction class
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_STATE;
            cls   <= CLS_MOV;
        end else begin
            state <= nextState;
            if (state == ST_DECODE)
                cls <= decCls;
        end
    end

    // Next state and control outputs; everything is forced idle while
    // reset is held so no enable can leak out during an abort.
    always_comb begin
        nextState  = state;
        fetch_req  = 1'b0;
        rIR_enable = 1'b0;
        wrEn       = 1'b0;
        wrCode     = irD;
        src_sel    = 3'd0;
        wb_sel     = WB_BUS;
        r1_enable  = 1'b0;
        r2_enable  = 1'b0;
        alu_op     = 3'd0;
        done       = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;
        if (rst_n) begin
            case (state)
                ST_IDLE: if (start) nextState = ST_FETCH;
                ST_FETCH: begin
                    fetch_req = 1'b1;
                    if (mem_ready) begin
                        rIR_enable = 1'b1;
                        nextState  = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (rIR_data == OPC_HLT) begin
                        done      = 1'b1;
                        nextState = ST_HALT;
                    end else if (decValid) begin
                        nextState = ST_EX1;
                    end else begin
                        illegal   = 1'b1;
                        done      = 1'b1;
                        nextState = AFTER_DONE;
                    end
                end
                ST_EX1: begin
                    alu_op = irD;
                    case (cls)
                        CLS_MOV: begin
                            src_sel   = irS;
                            wb_sel    = WB_REG;
                            wrEn      = 1'b1;
                            done      = 1'b1;
                            nextState = AFTER_DONE;
                        end
                        CLS_MVI: begin
                            // Operand byte comes straight off the bus
                            fetch_req = 1'b1;
                            if (mem_ready) begin
                                wb_sel    = WB_BUS;
                                wrEn      = 1'b1;
                                done      = 1'b1;
                                nextState = AFTER_DONE;
                            end
                        end
                        default: begin
                            src_sel   = REG_A;
                            r1_enable = 1'b1;
                            nextState = ST_EX2;
                        end
                    endcase
                end
                ST_EX2: begin
                    alu_op    = irD;
                    src_sel   = irS;
                    r2_enable = 1'b1;
                    nextState = ST_EX3;
                end
                ST_EX3: begin
                    // CMP only updates flags, so the accumulator is left alone
                    alu_op    = irD;
                    wb_sel    = WB_ALU;
                    wrCode    = REG_A;
                    wrEn      = (irD != ALU_CMP);
                    done      = 1'b1;
                    nextState = AFTER_DONE;
                end
                ST_HALT: begin
                    halted = 1'b1;
                    if (start) nextState = ST_FETCH;
                end
                default: nextState = ST_IDLE;
            endcase
        end
    end

    reg_onehot_dec uDec (
        .en     (wrEn),
        .code   (wrCode),
        .onehot (reg_en)
    );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: every cycle compares the full output
// vector against hand-computed values. A second instance checks the
// RESET_RUN=1 power-up behaviour.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start, mem_ready;
    logic [7:0] rIR_data;
    logic       fetch_req, rIR_enable, r1_enable, r2_enable, done, halted, illegal;
    logic [7:0] reg_en;
    logic [2:0] src_sel, alu_op;
    logic [1:0] wb_sel;

    logic       fetchReq2, irEn2, r1En2, r2En2, done2, halted2, illegal2;
    logic [7:0] regEn2;
    logic [2:0] srcSel2, aluOp2;
    logic [1:0] wbSel2;

    int nCmp = 0;
    int nBad = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.RESET_RUN(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_ready(mem_ready),
        .rIR_data(rIR_data), .fetch_req(fetch_req), .rIR_enable(rIR_enable),
        .reg_en(reg_en), .src_sel(src_sel), .wb_sel(wb_sel),
        .r1_enable(r1_enable), .r2_enable(r2_enable), .alu_op(alu_op),
        .done(done), .halted(halted), .illegal(illegal)
    );

    cpu_sequencer #(.RESET_RUN(1)) dutRun (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_ready(mem_ready),
        .rIR_data(rIR_data), .fetch_req(fetchReq2), .rIR_enable(irEn2),
        .reg_en(regEn2), .src_sel(srcSel2), .wb_sel(wbSel2),
        .r1_enable(r1En2), .r2_enable(r2En2), .alu_op(aluOp2),
        .done(done2), .halted(halted2), .illegal(illegal2)
    );

    wire [22:0] obs = {fetch_req, rIR_enable, reg_en, src_sel, wb_sel,
                       r1_enable, r2_enable, alu_op, done, halted, illegal};
    wire [22:0] obs2 = {fetchReq2, irEn2, regEn2, srcSel2, wbSel2,
                        r1En2, r2En2, aluOp2, done2, halted2, illegal2};

    // Pack an expected output vector in the same order as obs
    function automatic logic [22:0] ev(input logic fr, ire, input logic [7:0] re,
                                       input logic [2:0] ss, input logic [1:0] wb,
                                       input logic r1, r2, input logic [2:0] op,
                                       input logic dn, hl, il);
        return {fr, ire, re, ss, wb, r1, r2, op, dn, hl, il};
    endfunction

    task automatic chk(input string tag, input logic [22:0] got, input logic [22:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, compare mid-cycle, advance past next edge
    task automatic cyc(input logic st, mr, input logic [7:0] ir,
                       input logic [22:0] exp, input string tag);
        start = st; mem_ready = mr; rIR_data = ir;
        #2;
        chk(tag, obs, exp);
        @(posedge clk); #1;
    endtask

    localparam logic [22:0] Z  = 23'd0;

    initial begin
        logic [22:0] fetchHit, fetchWait;
        fetchHit  = ev(1,1,8'h00,0,0,0,0,0,0,0,0);
        fetchWait = ev(1,0,8'h00,0,0,0,0,0,0,0,0);
        rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0; rIR_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", obs, Z);
        chk("reset_run_outs", obs2, Z);
        rst_n = 1'b1;
        #1;
        chk("reset_run_release", obs2, fetchWait);
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            chk("reset_run_fetch", obs2, fetchWait);
            cyc(0, 0, 8'h00, Z, "idle");
        end

        // MOV B,A with zero-wait fetch
        cyc(1, 0, 8'h00, Z, "mov_idle_start");
        cyc(0, 1, 8'h00, fetchHit, "mov_fetch");
        cyc(0, 0, 8'h47, Z, "mov_decode");
        cyc(0, 0, 8'h47, ev(0,0,8'h01,3'd7,2'b01,0,0,3'd0,1,0,0), "mov_ex1");
`ifdef SINGLE_STEP_EN
        cyc(0, 0, 8'h47, Z, "ss_idle1");
        cyc(0, 1, 8'h47, Z, "ss_idle2");
        cyc(1, 0, 8'h47, Z, "ss_start2");
        cyc(0, 1, 8'h47, fetchHit, "ss_fetch2");
        cyc(0, 0, 8'h41, Z, "ss_decode2");
        cyc(0, 0, 8'h41, ev(0,0,8'h01,3'd1,2'b01,0,0,3'd0,1,0,0), "ss_ex1_2");
        cyc(0, 0, 8'h41, Z, "ss_idle3");
`else
        // MVI C,5Ah with two wait states on the operand
        cyc(0, 1, 8'h47, fetchHit, "mvi_fetch");
        cyc(0, 0, 8'h0E, Z, "mvi_decode");
        cyc(0, 0, 8'h0E, ev(1,0,8'h00,0,2'b00,0,0,3'd1,0,0,0), "mvi_wait1");
        cyc(1, 0, 8'h0E, ev(1,0,8'h00,0,2'b00,0,0,3'd1,0,0,0), "mvi_wait2");
        cyc(0, 1, 8'h0E, ev(1,0,8'h02,0,2'b00,0,0,3'd1,1,0,0), "mvi_ex1");

        // ADD D; stray start/mem_ready during EX must be ignored
        cyc(0, 1, 8'h0E, fetchHit, "add_fetch");
        cyc(0, 0, 8'h82, Z, "add_decode");
        cyc(1, 1, 8'h82, ev(0,0,8'h00,3'd7,0,1,0,3'd0,0,0,0), "add_ex1");
        cyc(0, 1, 8'h82, ev(0,0,8'h00,3'd2,0,0,1,3'd0,0,0,0), "add_ex2");
        cyc(0, 0, 8'h82, ev(0,0,8'h80,3'd0,2'b10,0,0,3'd0,1,0,0), "add_ex3");

        // CMP E: no register write
        cyc(0, 1, 8'h82, fetchHit, "cmp_fetch");
        cyc(0, 0, 8'hBB, Z, "cmp_decode");
        cyc(0, 0, 8'hBB, ev(0,0,8'h00,3'd7,0,1,0,3'd7,0,0,0), "cmp_ex1");
        cyc(0, 0, 8'hBB, ev(0,0,8'h00,3'd3,0,0,1,3'd7,0,0,0), "cmp_ex2");
        cyc(0, 0, 8'hBB, ev(0,0,8'h00,3'd0,2'b10,0,0,3'd7,1,0,0), "cmp_ex3");

        // MOV M,A and ADD M are unsupported
        cyc(0, 1, 8'hBB, fetchHit, "ill_fetch");
        cyc(0, 0, 8'h77, ev(0,0,8'h00,0,0,0,0,0,1,0,1), "ill_movm");
        cyc(0, 1, 8'h77, fetchHit, "ill_fetch2");
        cyc(0, 0, 8'h86, ev(0,0,8'h00,0,0,0,0,0,1,0,1), "ill_addm");

        // HLT, sit in HALT ignoring the bus, then resume on start
        cyc(0, 1, 8'h86, fetchHit, "hlt_fetch");
        cyc(0, 0, 8'h76, ev(0,0,8'h00,0,0,0,0,0,1,0,0), "hlt_decode");
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 8'h76, ev(0,0,8'h00,0,0,0,0,0,0,1,0), "halt_hold");
        cyc(1, 0, 8'h76, ev(0,0,8'h00,0,0,0,0,0,0,1,0), "halt_start");
        cyc(0, 0, 8'h76, fetchWait, "halt_fetch");

        // ADD D again, reset dropped in the middle of EX2
        cyc(0, 1, 8'h76, fetchHit, "rst_fetch");
        cyc(0, 0, 8'h82, Z, "rst_decode");
        cyc(0, 0, 8'h82, ev(0,0,8'h00,3'd7,0,1,0,3'd0,0,0,0), "rst_ex1");
        start = 1'b0; mem_ready = 1'b0; rIR_data = 8'h82;
        #2;
        chk("rst_ex2", obs, ev(0,0,8'h00,3'd2,0,0,1,3'd0,0,0,0));
        rst_n = 1'b0;
        #1;
        chk("rst_async", obs, Z);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(0, 0, 8'h82, Z, "rst_after1");
        cyc(0, 0, 8'h82, Z, "rst_after2");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
